// File: rtl/dpram_pkg.sv
// Shared constants for the dual-port RAM: read-during-write modes, default widths
// and output pipeline depth (PARAM_DUAL_RAM_OUTREG_EN adds one output stage).
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 7;

`ifdef PARAM_DUAL_RAM_OUTREG_EN
    localparam int OUT_STAGES = 2;
`else
    localparam int OUT_STAGES = 1;
`endif

endpackage

// File: rtl/param_dual_ram_if.sv
// Two-port RAM access bus: per-port enable/write/address/data requests and
// read data/valid responses, plus the shared collision flag.
interface param_dual_ram_if
    import dpram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              en1, en2;
    logic              wr1, wr2;
    logic [ADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0] d1, d2;
    logic [DATA_W-1:0] q1, q2;
    logic              vld1, vld2;
    logic              coll;

    modport master (
        output en1, en2, wr1, wr2, a1, a2, d1, d2,
        input  q1, q2, vld1, vld2, coll
    );

    modport slave (
        input  en1, en2, wr1, wr2, a1, a2, d1, d2,
        output q1, q2, vld1, vld2, coll
    );
endinterface

// File: rtl/dpram_port_pipe.sv
// Per-port output stage: captures read data on an accepted access and delays
// q/vld through STAGES registers; q holds its last value between accesses.
module dpram_port_pipe #(
    parameter int DATA_W = 8,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] q,
    output logic              vld
);
    logic [STAGES-1:0]             vld_pipe;
    logic [STAGES-1:0][DATA_W-1:0] q_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            q_pipe   <= '0;
        end else begin
            vld_pipe[0] <= acc;
            if (acc)
                q_pipe[0] <= rdata;
            // later stages copy unconditionally: stage 0 already holds between accesses
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                q_pipe[i]   <= q_pipe[i-1];
            end
        end
    end

    assign q   = q_pipe[STAGES-1];
    assign vld = vld_pipe[STAGES-1];
endmodule

// File: rtl/param_dual_ram.sv
// True dual-port RAM with port-1 write priority and collision flagging.
// PARAM_DUAL_RAM_OUTREG_EN adds an output register stage on q, vld and coll.
module param_dual_ram
    import dpram_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic                clk,
    input  logic                rst_n,
    param_dual_ram_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc1, acc2;
    logic              wen1, wen2;
    logic              same_addr;
    logic              coll_now;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic [OUT_STAGES-1:0] coll_pipe;

    // Accesses seen while reset is asserted are dropped, including writes.
    always_comb begin
        acc1      = bus.en1 & rst_n;
        acc2      = bus.en2 & rst_n;
        same_addr = (bus.a1 == bus.a2);
        wen1      = acc1 & bus.wr1;
        wen2      = acc2 & bus.wr2 & ~(wen1 & same_addr);
        coll_now  = acc1 & acc2 & same_addr & (bus.wr1 | bus.wr2);
        // Cross-port reads always see the pre-edge word; only a port's own write can bypass.
        rdata1    = (bus.wr1 && RDW_MODE == RDW_WRITE_FIRST) ? bus.d1 : mem[bus.a1];
        rdata2    = (bus.wr2 && RDW_MODE == RDW_WRITE_FIRST) ? bus.d2 : mem[bus.a2];
    end

    always_ff @(posedge clk) begin
        if (wen1)
            mem[bus.a1] <= bus.d1;
        if (wen2)
            mem[bus.a2] <= bus.d2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_pipe <= '0;
        end else begin
            coll_pipe[0] <= coll_now;
            for (int i = 1; i < OUT_STAGES; i++)
                coll_pipe[i] <= coll_pipe[i-1];
        end
    end

    assign bus.coll = coll_pipe[OUT_STAGES-1];

    dpram_port_pipe #(.DATA_W(DATA_W), .STAGES(OUT_STAGES)) u_pipe1 (
        .clk   (clk),
        .rst_n (rst_n),
        .acc   (acc1),
        .rdata (rdata1),
        .q     (bus.q1),
        .vld   (bus.vld1)
    );

    dpram_port_pipe #(.DATA_W(DATA_W), .STAGES(OUT_STAGES)) u_pipe2 (
        .clk   (clk),
        .rst_n (rst_n),
        .acc   (acc2),
        .rdata (rdata2),
        .q     (bus.q2),
        .vld   (bus.vld2)
    );
endmodule

// File: tb/tb_param_dual_ram.sv
// Randomized and directed bench for param_dual_ram against an array-based model
// of the port rules; honours PARAM_DUAL_RAM_OUTREG_EN (latency 2, write-first).
module tb_param_dual_ram;

`ifdef PARAM_DUAL_RAM_OUTREG_EN
    localparam int LAT = 2;
    localparam int RDW = 1;
`else
    localparam int LAT = 1;
    localparam int RDW = 0;
`endif

    typedef struct packed {
        logic       en1, wr1;
        logic [6:0] a1;
        logic [7:0] d1;
        logic       en2, wr2;
        logic [6:0] a2;
        logic [7:0] d2;
    } stim_t;

    typedef struct packed {
        logic [7:0] q1, q2;
        logic       vld1, vld2, coll;
        logic       k1, k2;
    } obs_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mmem [128];
    logic       mk   [128];
    logic [7:0] lq1, lq2;
    logic       lk1, lk2;
    obs_t       expq [$];

    param_dual_ram_if #(.DATA_W(8), .ADDR_W(7)) bus ();

    param_dual_ram #(.DATA_W(8), .ADDR_W(7), .RDW_MODE(RDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic e1, input logic w1, input logic [6:0] a1, input logic [7:0] d1,
                                 input logic e2, input logic w2, input logic [6:0] a2, input logic [7:0] d2);
        stim_t s;
        s.en1 = e1; s.wr1 = w1; s.a1 = a1; s.d1 = d1;
        s.en2 = e2; s.wr2 = w2; s.a2 = a2; s.d2 = d2;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(1'b0, 1'b0, 7'd0, 8'd0, 1'b0, 1'b0, 7'd0, 8'd0);
    endfunction

    // Called at a negedge: drives one cycle, books the expected response, returns at the next negedge.
    task automatic tick(input stim_t s, output logic have, output obs_t o, output obs_t e);
        obs_t x;
        bus.en1 = s.en1; bus.wr1 = s.wr1; bus.a1 = s.a1; bus.d1 = s.d1;
        bus.en2 = s.en2; bus.wr2 = s.wr2; bus.a2 = s.a2; bus.d2 = s.d2;
        x = '0;
        x.coll = s.en1 && s.en2 && (s.a1 == s.a2) && (s.wr1 || s.wr2);
        if (s.en1) begin
            if (s.wr1 && RDW != 0) begin lq1 = s.d1; lk1 = 1'b1; end
            else begin lq1 = mmem[s.a1]; lk1 = mk[s.a1]; end
        end
        if (s.en2) begin
            if (s.wr2 && RDW != 0) begin lq2 = s.d2; lk2 = 1'b1; end
            else begin lq2 = mmem[s.a2]; lk2 = mk[s.a2]; end
        end
        x.vld1 = s.en1; x.q1 = lq1; x.k1 = lk1;
        x.vld2 = s.en2; x.q2 = lq2; x.k2 = lk2;
        if (s.en1 && s.wr1) begin mmem[s.a1] = s.d1; mk[s.a1] = 1'b1; end
        if (s.en2 && s.wr2 && !(s.en1 && s.wr1 && s.a1 == s.a2)) begin mmem[s.a2] = s.d2; mk[s.a2] = 1'b1; end
        expq.push_back(x);
        @(negedge clk);
        o = '0;
        o.q1 = bus.q1; o.q2 = bus.q2; o.vld1 = bus.vld1; o.vld2 = bus.vld2; o.coll = bus.coll;
        have = 1'b0;
        e = '0;
        if (expq.size() == LAT) begin
            e = expq.pop_front();
            have = 1'b1;
        end
    endtask

    task automatic model_reset();
        expq.delete();
        lq1 = 8'h00; lq2 = 8'h00; lk1 = 1'b1; lk2 = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 128; i++) mk[i] = 1'b0;
        model_reset();
        rst_n = 1'b0;
        bus.en1 = 1'b0; bus.wr1 = 1'b0; bus.a1 = '0; bus.d1 = '0;
        bus.en2 = 1'b0; bus.wr2 = 1'b0; bus.a2 = '0; bus.d2 = '0;
        #12;
        n_cmp++; if (bus.q1 !== 8'h00)  begin n_bad++; $display("FAIL reset_q1: got %h want 00", bus.q1); end
        n_cmp++; if (bus.q2 !== 8'h00)  begin n_bad++; $display("FAIL reset_q2: got %h want 00", bus.q2); end
        n_cmp++; if (bus.vld1 !== 1'b0) begin n_bad++; $display("FAIL reset_vld1: got %b want 0", bus.vld1); end
        n_cmp++; if (bus.vld2 !== 1'b0) begin n_bad++; $display("FAIL reset_vld2: got %b want 0", bus.vld2); end
        n_cmp++; if (bus.coll !== 1'b0) begin n_bad++; $display("FAIL reset_coll: got %b want 0", bus.coll); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        stim_t s [$];
        obs_t o, e, got;
        logic have;
        got = 'x;
        s.push_back(st(1, 1, 7'h00, 8'hF0, 1, 1, 7'h01, 8'hF1));
        s.push_back(st(1, 0, 7'h00, 8'h00, 1, 0, 7'h01, 8'h00));
        s.push_back(idle()); s.push_back(idle());
        foreach (s[i]) begin
            tick(s[i], have, o, e);
            if (o.vld1 && o.vld2) got = o;
            if (have) begin
                n_cmp++;
                if (o.vld1 !== e.vld1 || o.vld2 !== e.vld2 || o.coll !== e.coll ||
                    (e.k1 && o.q1 !== e.q1) || (e.k2 && o.q2 !== e.q2)) begin
                    n_bad++;
                    $display("FAIL basic[%0d]: got q1=%h v1=%b q2=%h v2=%b c=%b want q1=%h v1=%b q2=%h v2=%b c=%b",
                             i, o.q1, o.vld1, o.q2, o.vld2, o.coll, e.q1, e.vld1, e.q2, e.vld2, e.coll);
                end
            end
        end
        n_cmp++;
        if (got.q1 !== 8'hF0 || got.q2 !== 8'hF1) begin
            n_bad++; $display("FAIL basic_read: got q1=%h q2=%h want q1=F0 q2=F1", got.q1, got.q2);
        end
    endtask

    task automatic test_coll_ww();
        stim_t s [$];
        obs_t o, e;
        logic have;
        int ncoll = 0;
        logic [7:0] last_q1 = 'x;
        s.push_back(st(1, 1, 7'h05, 8'hAA, 1, 1, 7'h05, 8'h55));
        s.push_back(st(1, 0, 7'h05, 8'h00, 0, 0, 7'h00, 8'h00));
        s.push_back(idle()); s.push_back(idle());
        foreach (s[i]) begin
            tick(s[i], have, o, e);
            if (o.coll) ncoll++;
            if (o.vld1) last_q1 = o.q1;
            if (have) begin
                n_cmp++;
                if (o.vld1 !== e.vld1 || o.vld2 !== e.vld2 || o.coll !== e.coll ||
                    (e.k1 && o.q1 !== e.q1) || (e.k2 && o.q2 !== e.q2)) begin
                    n_bad++;
                    $display("FAIL coll_ww[%0d]: got q1=%h v1=%b q2=%h v2=%b c=%b want q1=%h v1=%b q2=%h v2=%b c=%b",
                             i, o.q1, o.vld1, o.q2, o.vld2, o.coll, e.q1, e.vld1, e.q2, e.vld2, e.coll);
                end
            end
        end
        n_cmp++; if (ncoll != 1) begin n_bad++; $display("FAIL coll_ww_pulse: got %0d cycles want 1", ncoll); end
        n_cmp++; if (last_q1 !== 8'hAA) begin n_bad++; $display("FAIL coll_ww_data: got %h want AA", last_q1); end
    endtask

    task automatic test_coll_wr();
        stim_t s [$];
        obs_t o, e;
        logic have;
        logic [7:0] q2_at_coll = 'x;
        logic [7:0] last_q1 = 'x;
        s.push_back(st(1, 1, 7'h02, 8'h33, 0, 0, 7'h00, 8'h00));
        s.push_back(idle());
        s.push_back(st(1, 1, 7'h02, 8'h00, 1, 0, 7'h02, 8'h00));
        s.push_back(st(1, 0, 7'h02, 8'h00, 0, 0, 7'h00, 8'h00));
        s.push_back(idle()); s.push_back(idle());
        foreach (s[i]) begin
            tick(s[i], have, o, e);
            if (o.coll) q2_at_coll = o.q2;
            if (o.vld1) last_q1 = o.q1;
            if (have) begin
                n_cmp++;
                if (o.vld1 !== e.vld1 || o.vld2 !== e.vld2 || o.coll !== e.coll ||
                    (e.k1 && o.q1 !== e.q1) || (e.k2 && o.q2 !== e.q2)) begin
                    n_bad++;
                    $display("FAIL coll_wr[%0d]: got q1=%h v1=%b q2=%h v2=%b c=%b want q1=%h v1=%b q2=%h v2=%b c=%b",
                             i, o.q1, o.vld1, o.q2, o.vld2, o.coll, e.q1, e.vld1, e.q2, e.vld2, e.coll);
                end
            end
        end
        n_cmp++; if (q2_at_coll !== 8'h33) begin n_bad++; $display("FAIL coll_wr_old: got %h want 33", q2_at_coll); end
        n_cmp++; if (last_q1 !== 8'h00) begin n_bad++; $display("FAIL coll_wr_new: got %h want 00", last_q1); end
    endtask

    task automatic test_disabled();
        stim_t s [$];
        obs_t o, e;
        logic have;
        logic [7:0] last_q1 = 'x;
        s.push_back(st(1, 1, 7'h02, 8'h33, 0, 0, 7'h00, 8'h00));
        s.push_back(st(0, 1, 7'h02, 8'hFF, 0, 1, 7'h02, 8'hFF));
        s.push_back(st(1, 0, 7'h02, 8'h00, 0, 0, 7'h00, 8'h00));
        s.push_back(idle()); s.push_back(idle());
        foreach (s[i]) begin
            tick(s[i], have, o, e);
            if (o.vld1) last_q1 = o.q1;
            if (have) begin
                n_cmp++;
                if (o.vld1 !== e.vld1 || o.vld2 !== e.vld2 || o.coll !== e.coll ||
                    (e.k1 && o.q1 !== e.q1) || (e.k2 && o.q2 !== e.q2)) begin
                    n_bad++;
                    $display("FAIL disabled[%0d]: got q1=%h v1=%b q2=%h v2=%b c=%b want q1=%h v1=%b q2=%h v2=%b c=%b",
                             i, o.q1, o.vld1, o.q2, o.vld2, o.coll, e.q1, e.vld1, e.q2, e.vld2, e.coll);
                end
            end
        end
        n_cmp++; if (last_q1 !== 8'h33) begin n_bad++; $display("FAIL disabled_keep: got %h want 33", last_q1); end
    endtask

    task automatic test_reset_mid();
        stim_t s [$];
        obs_t o, e;
        logic have;
        logic [7:0] last_q1 = 'x;
        bus.en1 = 1; bus.wr1 = 0; bus.a1 = 7'h00; bus.en2 = 1; bus.wr2 = 0; bus.a2 = 7'h02;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.q1 !== 8'h00)  begin n_bad++; $display("FAIL rstmid_q1: got %h want 00", bus.q1); end
        n_cmp++; if (bus.q2 !== 8'h00)  begin n_bad++; $display("FAIL rstmid_q2: got %h want 00", bus.q2); end
        n_cmp++; if (bus.vld1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_vld1: got %b want 0", bus.vld1); end
        n_cmp++; if (bus.vld2 !== 1'b0) begin n_bad++; $display("FAIL rstmid_vld2: got %b want 0", bus.vld2); end
        n_cmp++; if (bus.coll !== 1'b0) begin n_bad++; $display("FAIL rstmid_coll: got %b want 0", bus.coll); end
        // A write presented at an edge while reset is held must not land.
        bus.en1 = 1; bus.wr1 = 1; bus.a1 = 7'h00; bus.d1 = 8'h99; bus.en2 = 0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.vld1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_hold_vld1: got %b want 0", bus.vld1); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        s.push_back(st(1, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00));
        s.push_back(idle()); s.push_back(idle());
        foreach (s[i]) begin
            tick(s[i], have, o, e);
            if (o.vld1) last_q1 = o.q1;
            if (have) begin
                n_cmp++;
                if (o.vld1 !== e.vld1 || o.vld2 !== e.vld2 || o.coll !== e.coll ||
                    (e.k1 && o.q1 !== e.q1) || (e.k2 && o.q2 !== e.q2)) begin
                    n_bad++;
                    $display("FAIL rstmid[%0d]: got q1=%h v1=%b q2=%h v2=%b c=%b want q1=%h v1=%b q2=%h v2=%b c=%b",
                             i, o.q1, o.vld1, o.q2, o.vld2, o.coll, e.q1, e.vld1, e.q2, e.vld2, e.coll);
                end
            end
        end
        n_cmp++; if (last_q1 !== 8'hF0) begin n_bad++; $display("FAIL rstmid_mem: got %h want F0", last_q1); end
    endtask

    task automatic test_wrap();
        stim_t s [$];
        obs_t o, e;
        logic have;
        logic [6:0] top_a = 7'h7F;
        logic [6:0] next_a;
        int first_vld = -1;
        logic [7:0] last_q1 = 'x;
        next_a = top_a + 7'd1;
        s.push_back(st(1, 1, top_a, 8'h3C, 0, 0, 7'h00, 8'h00));
        s.push_back(st(1, 0, next_a, 8'h00, 0, 0, 7'h00, 8'h00));
        s.push_back(idle()); s.push_back(idle());
        foreach (s[i]) begin
            tick(s[i], have, o, e);
            if (o.vld1 && first_vld < 0) first_vld = i;
            if (o.vld1) last_q1 = o.q1;
            if (have) begin
                n_cmp++;
                if (o.vld1 !== e.vld1 || o.vld2 !== e.vld2 || o.coll !== e.coll ||
                    (e.k1 && o.q1 !== e.q1) || (e.k2 && o.q2 !== e.q2)) begin
                    n_bad++;
                    $display("FAIL wrap[%0d]: got q1=%h v1=%b q2=%h v2=%b c=%b want q1=%h v1=%b q2=%h v2=%b c=%b",
                             i, o.q1, o.vld1, o.q2, o.vld2, o.coll, e.q1, e.vld1, e.q2, e.vld2, e.coll);
                end
            end
        end
        n_cmp++; if (first_vld != LAT - 1) begin n_bad++; $display("FAIL wrap_latency: got tick %0d want %0d", first_vld, LAT - 1); end
        n_cmp++; if (last_q1 !== 8'hF0) begin n_bad++; $display("FAIL wrap_addr0: got %h want F0", last_q1); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic have;
        stim_t s;
        for (int i = 0; i < 400; i++) begin
            if (i >= 396) s = idle();
            else begin
                s.en1 = ($urandom_range(0, 3) != 0);
                s.wr1 = $urandom_range(0, 1);
                s.a1  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
                s.d1  = 8'($urandom);
                s.en2 = ($urandom_range(0, 3) != 0);
                s.wr2 = $urandom_range(0, 1);
                s.a2  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
                s.d2  = 8'($urandom);
            end
            tick(s, have, o, e);
            if (have) begin
                n_cmp++;
                if (o.vld1 !== e.vld1 || o.vld2 !== e.vld2 || o.coll !== e.coll ||
                    (e.k1 && o.q1 !== e.q1) || (e.k2 && o.q2 !== e.q2)) begin
                    n_bad++;
                    $display("FAIL b2b[%0d]: got q1=%h v1=%b q2=%h v2=%b c=%b want q1=%h v1=%b q2=%h v2=%b c=%b",
                             i, o.q1, o.vld1, o.q2, o.vld2, o.coll, e.q1, e.vld1, e.q2, e.vld2, e.coll);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coll_ww();
        test_coll_wr();
        test_disabled();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_dual_ram.md
PARAM_DUAL_RAM -- requirements
Module: param_dual_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width per word in bits (range 1..64).
REQ-002 SHALL have parameter ADDR_W, default 7, address width; depth is 2**ADDR_W words.
REQ-003 SHALL have parameter RDW_MODE, default 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have port clk, input, 1, the single clock; every register samples on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-006 SHALL have ports en1 / en2, input, 1, port access enable; no read or write occurs when low.
REQ-007 SHALL have ports wr1 / wr2, input, 1, write select, qualified by en1 / en2.
REQ-008 SHALL have ports a1 / a2, input, ADDR_W, port address.
REQ-009 SHALL have ports d1 / d2, input, DATA_W, write data.
REQ-010 SHALL have ports q1 / q2, output, DATA_W, read data.
REQ-011 SHALL have ports vld1 / vld2, output, 1, q1 / q2 holds the result of an accepted access.
REQ-012 SHALL have port coll, output, 1, one-cycle pulse flagging an address collision.

Function
REQ-013 An access is accepted on port n at a rising clk edge when enn=1; a write when wrn=1, otherwise a read.
REQ-014 A read SHALL update qn, and vldn SHALL pulse high, one clk cycle after acceptance (base latency 1).
REQ-015 An accepted write SHALL also drive qn and pulse vldn at latency 1, using RDW_MODE: old word (0) or dn (1).
REQ-016 With enn=0, qn SHALL hold its last value and vldn SHALL be 0 on the following cycle.
REQ-017 Accesses on both ports in the same cycle to different addresses SHALL complete independently.
REQ-018 Both ports writing the same address in one cycle: port 1 data SHALL be stored, port 2 write dropped, coll=1 next cycle.
REQ-019 One port writing and the other reading the same address in one cycle: the reader SHALL return the old word, coll=1 next cycle.
REQ-020 Both ports reading the same address SHALL NOT assert coll.
REQ-021 Addresses SHALL wrap modulo 2**ADDR_W, with no out-of-range case.
REQ-022 Memory contents SHALL be undefined until written; the bench SHALL NOT rely on initial contents.

Reset
REQ-023 While rst_n=0: q1=q2=0, vld1=vld2=0, coll=0, and all pipeline registers cleared, asynchronously.
REQ-024 Reset SHALL NOT clear memory contents.
REQ-025 A write accepted in the same edge that rst_n is low SHALL be discarded.
REQ-026 Access resumes on the first rising edge after rst_n deasserts.
REQ-027 An access in flight at reset assertion SHALL produce no vld pulse.

Configuration
REQ-028 Macro PARAM_DUAL_RAM_OUTREG_EN defined: one extra output register stage per port on q, vld and coll; latency becomes 2 for all outputs.
REQ-029 Macro PARAM_DUAL_RAM_OUTREG_EN undefined: latency 1 per REQ-014; no extra stage.

Structure
REQ-030 Package dpram_pkg SHALL hold RDW_READ_FIRST=0, RDW_WRITE_FIRST=1 and the default widths.
REQ-031 The per-port output stage (q/vld register plus optional OUTREG stage) SHALL be sub-module dpram_port_pipe, instantiated twice.
REQ-032 Storage array, collision compare and write arbitration SHALL reside in param_dual_ram.

Verification (DATA_W=8, ADDR_W=7, OUTREG off unless stated)
REQ-033 Write port1 0xF0 @0x00 and port2 0xF1 @0x01, then read both -> q1=0xF0, q2=0xF1, vld1=vld2=1 one cycle after the read.
REQ-034 Both ports write @0x05, d1=0xAA, d2=0x55 -> coll pulse; read @0x05 returns 0xAA.
REQ-035 @0x02 holds 0x33; port1 writes 0x00 @0x02 while port2 reads @0x02 -> q2=0x33, coll=1; next read -> 0x00.
REQ-036 en1=en2=0 with wr1=wr2=1, d=0xFF @0x02 -> no write, vld=0; later read @0x02 still returns prior 0x33.
REQ-037 Pulse rst_n low mid-stream -> q=0, vld=0, coll=0 immediately; read @0x00 after release returns 0xF0.
REQ-038 With PARAM_DUAL_RAM_OUTREG_EN defined and RDW_MODE=1, write 0x3C @0x7F -> q1=0x3C with vld1 two cycles later; address 0x7F+1 wraps to 0x00.
